// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the pwm_multi_dither slice: width helpers,
// saturating increment and the PRESCALE legal range.
package pwm_multi_pkg;

  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 1024;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  // Select / counter width, never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int duty_width(input int w, input int f);
    return w + f;
  endfunction

  // v + c, clamped at 2^w - 1.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic c, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    if (c && (v < max_v)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, optional first-order dither
// (PWM_DITHER_EN) and the registered compare output.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wrap,
  input  logic                  load,
  input  logic [WIDTH+FRAC-1:0] shadow,
  input  logic [WIDTH-1:0]      cnt,
  output logic                  pwm_out
);

  logic [WIDTH-1:0] active;

`ifdef PWM_DITHER_EN
  logic [WIDTH+FRAC-1:0] committed;
  logic [WIDTH+FRAC-1:0] src;
  logic [FRAC:0]         acc;
  logic [FRAC-1:0]       err;
  logic [WIDTH-1:0]      active_nxt;

  // On the commit wrap the fresh shadow is used directly as the source.
  always_comb begin
    src        = load ? shadow : committed;
    acc        = {1'b0, err} + {1'b0, src[FRAC-1:0]};
    active_nxt = WIDTH'(sat_inc(32'(src[WIDTH+FRAC-1:FRAC]), acc[FRAC], WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= '0;
      err       <= '0;
      active    <= '0;
    end else begin
      if (load) committed <= shadow;
      if (wrap) begin
        active <= active_nxt;
        err    <= acc[FRAC-1:0];
      end
    end
  end
`else
  logic unused_dither;
  assign unused_dither = ^{shadow[FRAC-1:0], wrap};

  always_ff @(posedge clk) begin
    if (rst) active <= '0;
    else if (load) active <= shadow[WIDTH+FRAC-1:FRAC];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= enable & (cnt < active);
  end

endmodule

// File: rtl/pwm_multi_dither.sv
// Multi-channel PWM: prescaler, period counter, shadow bank and commit FSM.
// Optional dither of fractional duty bits when PWM_DITHER_EN is defined.
//   state      | meaning
//   ST_IDLE    | no commit armed, shadow bank writable
//   ST_PENDING | commit armed, shadows locked until the next wrap
module pwm_multi_dither
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int PRESCALE = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       enable,
  input  logic                                       duty_valid,
  output logic                                       duty_ready,
  input  logic [sel_width(CHANNELS)-1:0]             duty_ch,
  input  logic [duty_width(WIDTH, FRAC)-1:0]         duty_val,
  input  logic                                       commit,
  output logic [CHANNELS-1:0]                        pwm_out,
  output logic                                       period_start,
  output logic                                       pending
);

  localparam int CH_W = sel_width(CHANNELS);
  localparam int PS_W = sel_width(PRESCALE);
  localparam int DW   = duty_width(WIDTH, FRAC);

  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("pwm_multi_dither: PRESCALE out of range");
  end

  logic [PS_W-1:0] ps_cnt;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             wrap;
  logic             load;
  logic             wr_en;
  commit_state_e    state;
  logic [DW-1:0]    shadow [CHANNELS];

  assign tick       = (ps_cnt == PS_W'(PRESCALE - 1));
  assign wrap       = tick && (cnt == {WIDTH{1'b1}});
  assign pending    = (state == ST_PENDING);
  assign load       = wrap && pending;
  assign duty_ready = !rst && !pending;
  assign wr_en      = duty_valid && duty_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt       <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      ps_cnt       <= tick ? '0 : ps_cnt + PS_W'(1);
      if (tick) cnt <= cnt + WIDTH'(1);
      period_start <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (commit) state <= ST_PENDING;
        ST_PENDING: if (wrap)   state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range channel writes are accepted and simply match no entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) shadow[c] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < CHANNELS; c++)
        if (duty_ch == CH_W'(c)) shadow[c] <= duty_val;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wrap    (wrap),
      .load    (load),
      .shadow  (shadow[g]),
      .cnt     (cnt),
      .pwm_out (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_dither.sv
// Bench for pwm_multi_dither: time-indexed behavioural model with per-cycle
// compare, plus literal high-time checks for the directed scenarios.
module tb_pwm_multi_dither;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 4;
  localparam int FRAC     = 2;
  localparam int PRESCALE = 2;
  localparam int DW       = WIDTH + FRAC;
  localparam int NCNT     = 1 << WIDTH;
  localparam int PERIOD   = NCNT * PRESCALE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b1;
  logic                duty_valid = 1'b0;
  logic [0:0]          duty_ch = '0;
  logic [DW-1:0]       duty_val = '0;
  logic                commit = 1'b0;
  logic                duty_ready;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;
  logic                pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi_dither #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .commit       (commit),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .pending      (pending)
  );

  // Reference model: k counts clocks since reset; counter value and wrap
  // follow from k by division, duty bookkeeping uses plain integers.
  int                  k = 0;
  bit                  m_pend = 0;
  int                  m_shadow [CHANNELS];
  int                  m_active [CHANNELS];
  int                  m_comm   [CHANNELS];
  int                  m_err    [CHANNELS];
  logic [CHANNELS-1:0] exp_pwm = '0;
  logic                exp_ps = 1'b0;
  bit                  m_wrap, m_ld;
  int                  m_src, m_acc;

  initial for (int c = 0; c < CHANNELS; c++) begin
    m_shadow[c] = 0; m_active[c] = 0; m_comm[c] = 0; m_err[c] = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_pend = 0; exp_pwm = '0; exp_ps = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_shadow[c] = 0; m_active[c] = 0; m_comm[c] = 0; m_err[c] = 0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        exp_pwm[c] = enable && (((k / PRESCALE) % NCNT) < m_active[c]);
      m_wrap = (k % PERIOD) == PERIOD - 1;
      m_ld   = m_wrap && m_pend;
      for (int c = 0; c < CHANNELS; c++) begin
`ifdef PWM_DITHER_EN
        if (m_wrap) begin
          m_src = m_ld ? m_shadow[c] : m_comm[c];
          if (m_ld) m_comm[c] = m_src;
          m_acc = m_err[c] + (m_src % (1 << FRAC));
          m_active[c] = (m_src >> FRAC) + (m_acc >> FRAC);
          if (m_active[c] > NCNT - 1) m_active[c] = NCNT - 1;
          m_err[c] = m_acc % (1 << FRAC);
        end
`else
        if (m_ld) m_active[c] = m_shadow[c] >> FRAC;
`endif
      end
      if (duty_valid && !m_pend && (int'(duty_ch) < CHANNELS))
        m_shadow[duty_ch] = int'(duty_val);
      if (m_ld) m_pend = 0;
      else if (commit && !m_pend) m_pend = 1;
      exp_ps = m_wrap;
      k++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check("period_start", 32'(period_start), 32'(exp_ps));
    check("pending", 32'(pending), 32'(m_pend));
    check("duty_ready", 32'(duty_ready), 32'(!rst && !m_pend));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int val, input bit with_commit);
    duty_valid = 1'b1;
    duty_ch    = ch[0:0];
    duty_val   = val[DW-1:0];
    commit     = with_commit;
    cyc();
    duty_valid = 1'b0;
    commit     = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 4 * PERIOD);
    check("period_start_timeout", 32'(period_start), 32'd1);
  endtask

  // Starting just after a period_start cycle, count high clocks per channel.
  task automatic measure(input int nper, output int h0, output int h1,
                         output int nps, output int n_long);
    int per;
    h0 = 0; h1 = 0; nps = 0; n_long = 0;
    for (int p = 0; p < nper; p++) begin
      per = 0;
      for (int i = 0; i < PERIOD; i++) begin
        @(negedge clk);
        per += int'(pwm_out[0]);
        h1  += int'(pwm_out[1]);
        nps += int'(period_start);
      end
      h0 += per;
      if (per > 16) n_long++;
    end
  endtask

  int h0, h1, nps, nlong;

  initial begin
    repeat (3) cyc();
    check("rst_ready", 32'(duty_ready), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(duty_ready), 32'd1);

    // ch0 = 8.0 -> 16 of 32 clocks high, ch1 low
    write(0, 'h20, 1'b0);
    do_commit();
    check("pending_set", 32'(pending), 32'd1);
    wait_ps();
    check("pending_clr", 32'(pending), 32'd0);
    measure(1, h0, h1, nps, nlong);
    check("ch0_half", 32'(h0), 32'd16);
    check("ch1_low", 32'(h1), 32'd0);

    // ch1 = 15.0 -> 30 high, then 0 -> constant low
    write(1, 'h3C, 1'b0);
    do_commit();
    wait_ps();
    measure(1, h0, h1, nps, nlong);
    check("ch1_max", 32'(h1), 32'd30);
    check("ch0_keep", 32'(h0), 32'd16);
    write(1, 0, 1'b0);
    do_commit();
    wait_ps();
    measure(1, h0, h1, nps, nlong);
    check("ch1_zero", 32'(h1), 32'd0);

    // Write while pending is refused; second commit ignored
    do_commit();
    check("ready_pending", 32'(duty_ready), 32'd0);
    write(0, 'h08, 1'b0);
    do_commit();
    wait_ps();
    check("pending_after_wrap", 32'(pending), 32'd0);
    check("ready_after_wrap", 32'(duty_ready), 32'd1);
    measure(1, h0, h1, nps, nlong);
    check("ch0_unchanged", 32'(h0), 32'd16);

    // Write and commit in the same cycle
    write(0, 'h10, 1'b1);
    check("pending_same_cycle", 32'(pending), 32'd1);
    wait_ps();
    measure(1, h0, h1, nps, nlong);
    check("ch0_quarter", 32'(h0), 32'd8);

    // 8.25 -> one period in four is one count longer with dither
    write(0, 'h21, 1'b1);
    wait_ps();
    measure(4, h0, h1, nps, nlong);
`ifdef PWM_DITHER_EN
    check("dither_total", 32'(h0), 32'd66);
    check("dither_long", 32'(nlong), 32'd1);
`else
    check("trunc_total", 32'(h0), 32'd64);
    check("trunc_long", 32'(nlong), 32'd0);
`endif

    // enable=0: outputs low, period_start keeps pulsing
    write(0, 'h20, 1'b1);
    wait_ps();
    enable = 1'b0;
    wait_ps();
    measure(2, h0, h1, nps, nlong);
    check("disabled_ch0", 32'(h0), 32'd0);
    check("disabled_ps", 32'(nps), 32'd2);

    // Reset while pending loses the commit
    write(0, 'h30, 1'b1);
    repeat (5) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_pwm_mid", 32'(pwm_out), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    #1;
    check("ready_rerelease", 32'(duty_ready), 32'd1);
    wait_ps();
    measure(1, h0, h1, nps, nlong);
    check("after_rst_ch0", 32'(h0), 32'd0);

    // Randomised traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_ch    = 1'($urandom_range(0, 1));
      duty_val   = DW'($urandom);
      commit     = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0; duty_valid = 1'b0; commit = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
